stopwatch_ctrl: RTL and testbench

Mode controller for the MM:SS stopwatch counter. It turns debounced start/lap/clear buttons into a 2-bit run state and a single-cycle count enable per 1 Hz tick. It issues clear pulses to the counter, captures lap times, and muxes live or frozen digits toward the seven-segment display driver. It sits between the button debouncers, the 1 Hz tick generator, the BCD counter and the display mux.

---
 rtl/stopwatch_ctrl.sv | 150 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run-state FSM, count strobe, clear pulse, lap capture and display mux
module stopwatch_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic       switch_en,
  input  logic [3:0] num0,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [3:0] num3,
  output logic [1:0] state,
  output logic       count_en,
  output logic       clear,
  output logic       disp_freeze,
  output logic [3:0] lap_count,
  output logic [3:0] disp0,
  output logic [3:0] disp1,
  output logic [3:0] disp2,
  output logic [3:0] disp3
);

  localparam int unsigned DW     = 4;
  localparam int unsigned LC_MAX = 15;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_LAP    = 2'd2,
    S_PAUSED = 2'd3
  } state_t;

  state_t        cur_state;
  state_t        nxt_state;
  logic          start_q;
  logic          lap_q;
  logic          clear_q;
  logic          start_act;
  logic          lap_act;
  logic          clear_act;
  logic          clear_nxt;
  logic          count_en_nxt;
  logic          capture;
  logic          zero_laps;
  logic [DW-1:0] lap0;
  logic [DW-1:0] lap1;
  logic [DW-1:0] lap2;
  logic [DW-1:0] lap3;

  // Rising edges, discarded outright while stopwatch mode is off
  assign start_act = switch_en & btn_start & ~start_q;
  assign lap_act   = switch_en & btn_lap   & ~lap_q;
  assign clear_act = switch_en & btn_clear & ~clear_q;

  // State register, strobes, button history, lap registers and lap counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_IDLE;
      start_q   <= 1'b0;
      lap_q     <= 1'b0;
      clear_q   <= 1'b0;
      count_en  <= 1'b0;
      clear     <= 1'b0;
      lap_count <= '0;
      lap0      <= '0;
      lap1      <= '0;
      lap2      <= '0;
      lap3      <= '0;
    end else begin
      cur_state <= nxt_state;
      start_q   <= btn_start;
      lap_q     <= btn_lap;
      clear_q   <= btn_clear;
      count_en  <= count_en_nxt;
      clear     <= clear_nxt;
      if (zero_laps) begin
        lap_count <= '0;
        lap0      <= '0;
        lap1      <= '0;
        lap2      <= '0;
        lap3      <= '0;
      end else if (capture) begin
        lap0 <= num0;
        lap1 <= num1;
        lap2 <= num2;
        lap3 <= num3;
        if (lap_count != DW'(LC_MAX)) begin
          lap_count <= lap_count + DW'(1);
        end
      end
    end
  end

  // Next state and actions; start outranks clear, clear outranks lap, among rises valid here
  always_comb begin
    nxt_state    = cur_state;
    clear_nxt    = 1'b0;
    capture      = 1'b0;
    zero_laps    = 1'b0;
    count_en_nxt = tick & ((cur_state == S_RUN) | (cur_state == S_LAP));
    case (cur_state)
      S_IDLE: begin
        if (start_act) begin
          nxt_state = S_RUN;
        end else if (clear_act) begin
          clear_nxt = 1'b1;
          zero_laps = 1'b1;
        end
      end
      S_RUN: begin
        if (start_act) begin
          nxt_state = S_PAUSED;
        end else if (lap_act) begin
          nxt_state = S_LAP;
          capture   = 1'b1;
        end
      end
      S_LAP: begin
        if (start_act) begin
          nxt_state = S_PAUSED;
        end else if (clear_act) begin
          nxt_state = S_RUN;
        end else if (lap_act) begin
          capture = 1'b1;
        end
      end
      S_PAUSED: begin
        if (start_act) begin
          nxt_state = S_RUN;
        end else if (clear_act) begin
          nxt_state = S_IDLE;
          clear_nxt = 1'b1;
          zero_laps = 1'b1;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Frozen lap digits while in LAP, live counter digits otherwise
  assign state       = cur_state;
  assign disp_freeze = (cur_state == S_LAP);
  assign disp0       = disp_freeze ? lap0 : num0;
  assign disp1       = disp_freeze ? lap1 : num1;
  assign disp2       = disp_freeze ? lap2 : num2;
  assign disp3       = disp_freeze ? lap3 : num3;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: vector table plus hand sequences for stopwatch_ctrl
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        btn_start;
  logic        btn_lap;
  logic        btn_clear;
  logic        switch_en;
  logic [15:0] num;
  logic [1:0]  state;
  logic        count_en;
  logic        clear;
  logic        disp_freeze;
  logic [3:0]  lap_count;
  logic [3:0]  disp0, disp1, disp2, disp3;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic        sw;
    logic        st;
    logic        lp;
    logic        cl;
    logic        tk;
    logic [15:0] num;
    logic [1:0]  e_state;
    logic        e_ce;
    logic        e_clr;
    logic [3:0]  e_lc;
    logic [15:0] e_disp;
  } vec_t;

  localparam int NV = 23;
  vec_t tv [NV];

  stopwatch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .btn_start   (btn_start),
    .btn_lap     (btn_lap),
    .btn_clear   (btn_clear),
    .switch_en   (switch_en),
    .num0        (num[3:0]),
    .num1        (num[7:4]),
    .num2        (num[11:8]),
    .num3        (num[15:12]),
    .state       (state),
    .count_en    (count_en),
    .clear       (clear),
    .disp_freeze (disp_freeze),
    .lap_count   (lap_count),
    .disp0       (disp0),
    .disp1       (disp1),
    .disp2       (disp2),
    .disp3       (disp3)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [15:0] disp_all();
    return {disp3, disp2, disp1, disp0};
  endfunction

  task automatic set_v(input int i, input logic sw, input logic st, input logic lp,
                       input logic cl, input logic tk, input logic [15:0] n,
                       input logic [1:0] es, input logic ece, input logic eclr,
                       input logic [3:0] elc, input logic [15:0] ed);
    tv[i] = {sw, st, lp, cl, tk, n, es, ece, eclr, elc, ed};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n_ce;
    int clr_seen;
    logic [15:0] lap_num;

    //       i  sw st lp cl tk num       state ce clr lc disp
    set_v( 0, 1, 1, 0, 0, 0, 16'h0000, 2'd1, 0, 0, 4'd0, 16'h0000);
    set_v( 1, 1, 0, 0, 0, 1, 16'h0000, 2'd1, 1, 0, 4'd0, 16'h0000);
    set_v( 2, 1, 0, 0, 0, 0, 16'h0000, 2'd1, 0, 0, 4'd0, 16'h0000);
    set_v( 3, 1, 0, 1, 0, 0, 16'h0250, 2'd2, 0, 0, 4'd1, 16'h0250);
    set_v( 4, 1, 0, 0, 0, 1, 16'h0251, 2'd2, 1, 0, 4'd1, 16'h0250);
    set_v( 5, 1, 0, 0, 1, 0, 16'h0252, 2'd1, 0, 0, 4'd1, 16'h0252);
    set_v( 6, 1, 0, 0, 0, 0, 16'h1234, 2'd1, 0, 0, 4'd1, 16'h1234);
    set_v( 7, 1, 1, 1, 1, 1, 16'h1234, 2'd3, 1, 0, 4'd1, 16'h1234);
    set_v( 8, 1, 0, 0, 0, 1, 16'h1234, 2'd3, 0, 0, 4'd1, 16'h1234);
    set_v( 9, 1, 0, 0, 1, 0, 16'h1234, 2'd0, 0, 1, 4'd0, 16'h1234);
    set_v(10, 1, 0, 1, 0, 0, 16'h1234, 2'd0, 0, 0, 4'd0, 16'h1234);
    set_v(11, 1, 1, 0, 0, 0, 16'h1234, 2'd1, 0, 0, 4'd0, 16'h1234);
    set_v(12, 0, 0, 0, 0, 0, 16'h1234, 2'd1, 0, 0, 4'd0, 16'h1234);
    set_v(13, 0, 1, 1, 1, 1, 16'h1234, 2'd1, 1, 0, 4'd0, 16'h1234);
    set_v(14, 0, 0, 0, 0, 0, 16'h1234, 2'd1, 0, 0, 4'd0, 16'h1234);
    set_v(15, 0, 1, 0, 0, 0, 16'h1234, 2'd1, 0, 0, 4'd0, 16'h1234);
    set_v(16, 1, 1, 0, 0, 1, 16'h1234, 2'd1, 1, 0, 4'd0, 16'h1234);
    set_v(17, 1, 0, 0, 0, 0, 16'h1234, 2'd1, 0, 0, 4'd0, 16'h1234);
    set_v(18, 1, 1, 0, 0, 0, 16'h1234, 2'd3, 0, 0, 4'd0, 16'h1234);
    set_v(19, 1, 1, 0, 0, 1, 16'h1234, 2'd3, 0, 0, 4'd0, 16'h1234);
    set_v(20, 1, 0, 0, 0, 0, 16'h1234, 2'd3, 0, 0, 4'd0, 16'h1234);
    set_v(21, 1, 1, 0, 0, 1, 16'h1234, 2'd1, 0, 0, 4'd0, 16'h1234);
    set_v(22, 1, 0, 0, 1, 0, 16'h1234, 2'd1, 0, 0, 4'd0, 16'h1234);

    tick = 1'b0; btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    switch_en = 1'b1; num = 16'h4321;
    do_reset();

    // Reset state: all registered outputs zero, display follows live digits
    chk("reset state", 16'(state), 16'd0);
    chk("reset count_en", 16'(count_en), 16'd0);
    chk("reset clear", 16'(clear), 16'd0);
    chk("reset lap_count", 16'(lap_count), 16'd0);
    chk("reset disp", disp_all(), 16'h4321);

    // Start then 12 ticks: one strobe per tick, one cycle later
    btn_start = 1'b1; step(); btn_start = 1'b0;
    chk("start state", 16'(state), 16'd1);
    n_ce = 0; clr_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick = 1'b1; step();
      chk($sformatf("tick%0d count_en", i), 16'(count_en), 16'd1);
      if (count_en) n_ce++;
      if (clear) clr_seen++;
      tick = 1'b0; step();
      chk($sformatf("tick%0d count_en gap", i), 16'(count_en), 16'd0);
      if (count_en) n_ce++;
      if (clear) clr_seen++;
    end
    chk("strobe total", 16'(n_ce), 16'd12);
    chk("clear never high", 16'(clr_seen), 16'd0);

    // Vector table from a fresh reset
    do_reset();
    for (int i = 0; i < NV; i++) begin
      switch_en = tv[i].sw; btn_start = tv[i].st; btn_lap = tv[i].lp;
      btn_clear = tv[i].cl; tick = tv[i].tk; num = tv[i].num;
      step();
      chk($sformatf("v%0d state", i), 16'(state), 16'(tv[i].e_state));
      chk($sformatf("v%0d count_en", i), 16'(count_en), 16'(tv[i].e_ce));
      chk($sformatf("v%0d clear", i), 16'(clear), 16'(tv[i].e_clr));
      chk($sformatf("v%0d lap_count", i), 16'(lap_count), 16'(tv[i].e_lc));
      chk($sformatf("v%0d disp", i), disp_all(), tv[i].e_disp);
    end
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0; tick = 1'b0;
    step();

    // RUN -> PAUSED, five ticks ignored, then clear back to IDLE
    btn_start = 1'b1; step(); btn_start = 1'b0;
    chk("pause state", 16'(state), 16'd3);
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      chk($sformatf("paused tick%0d", i), 16'(count_en), 16'd0);
    end
    btn_clear = 1'b1; step(); btn_clear = 1'b0;
    chk("paused clear pulse", 16'(clear), 16'd1);
    chk("paused clear state", 16'(state), 16'd0);
    chk("paused clear lap_count", 16'(lap_count), 16'd0);
    step();
    chk("clear pulse width", 16'(clear), 16'd0);

    // 17 laps: count saturates at 15, digits still recaptured
    btn_start = 1'b1; step(); btn_start = 1'b0; step();
    lap_num = 16'h0;
    for (int i = 0; i < 17; i++) begin
      lap_num = 16'h0100 | (16'(i / 10) << 4) | 16'(i % 10);
      num = lap_num;
      btn_lap = 1'b1; step(); btn_lap = 1'b0;
      chk($sformatf("lap%0d count", i), 16'(lap_count), 16'((i + 1 > 15) ? 15 : i + 1));
      chk($sformatf("lap%0d disp", i), disp_all(), lap_num);
      num = 16'h0999; step();
    end
    chk("lap final state", 16'(state), 16'd2);
    chk("lap frozen disp", disp_all(), 16'h0116);
    chk("lap freeze flag", 16'(disp_freeze), 16'd1);

    // Reset mid-run overrides a concurrent tick and lap rise
    tick = 1'b1; btn_lap = 1'b1; reset = 1'b1; step();
    tick = 1'b0; btn_lap = 1'b0;
    chk("midreset state", 16'(state), 16'd0);
    chk("midreset count_en", 16'(count_en), 16'd0);
    chk("midreset clear", 16'(clear), 16'd0);
    chk("midreset lap_count", 16'(lap_count), 16'd0);
    chk("midreset disp", disp_all(), 16'h0999);

    // Start held through reset release acts on the first cycle after reset
    btn_start = 1'b1; step();
    chk("held in reset state", 16'(state), 16'd0);
    reset = 1'b0; step();
    chk("held after reset state", 16'(state), 16'd1);
    btn_start = 1'b0; step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
